// File: rtl/sha256_hk_sequencer_pkg.sv
// Shared states, word counts and issue-tag layout for the SHA-256 H/K constant sequencer.
package sha256_hk_sequencer_pkg;

    localparam int unsigned H_WORDS = 8;
    localparam int unsigned K_WORDS = 64;
    localparam logic [5:0]  H_LAST  = 6'(H_WORDS - 1);
    localparam logic [5:0]  K_LAST  = 6'(K_WORDS - 1);
    localparam logic        HSEL    = 1'b0;
    localparam logic        KSEL    = 1'b1;

    typedef enum logic [2:0] {
        ST_INIT,
        ST_READY,
        ST_LOAD_H,
        ST_ROUNDS,
        ST_FINAL_H,
        ST_DRAIN
    } state_t;

    typedef struct packed {
        logic       h_v;
        logic       k_v;
        logic       fin;
        logic [5:0] idx;
    } hk_tag_t;

endpackage

// File: rtl/sha256_hk_sequencer_valid_pipe.sv
// Delays the per-address issue tag by the HK memory read latency; holds on stall, clears on flush.
module hk_valid_pipe
    import sha256_hk_sequencer_pkg::*;
#(
    parameter int unsigned HK_RD_LAT = 1
) (
    input  logic    clk,
    input  logic    rst_n,
    input  logic    en,
    input  logic    flush,
    input  hk_tag_t din,
    output hk_tag_t dout
);

    if (HK_RD_LAT == 0) begin : g_wire
        assign dout = din;
    end else begin : g_pipe
        hk_tag_t stage [HK_RD_LAT];

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                for (int unsigned i = 0; i < HK_RD_LAT; i++) stage[i] <= '0;
            end else if (flush) begin
                for (int unsigned i = 0; i < HK_RD_LAT; i++) stage[i] <= '0;
            end else if (en) begin
                stage[0] <= din;
                for (int unsigned i = 1; i < HK_RD_LAT; i++) stage[i] <= stage[i-1];
            end
        end

        assign dout = stage[HK_RD_LAT-1];
    end

endmodule

// File: rtl/sha256_hk_sequencer.sv
// Walks the H/K constant memory for one SHA-256 block: H init, 64 K rounds, H final add.
module sha256_hk_sequencer
    import sha256_hk_sequencer_pkg::*;
#(
    parameter int unsigned HK_RD_LAT = 1
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic       START,
    input  logic       STALL,
    input  logic       ABORT,
    input  logic       MEM_RDY,
    output logic       COPY_ROM,
    output logic       HK_SELECTOR,
    output logic [2:0] H_ADDR,
    output logic [5:0] K_ADDR,
    output logic       H_VALID,
    output logic       K_VALID,
    output logic       FINAL,
    output logic [5:0] IDX,
    output logic       INIT_DONE,
    output logic       BUSY,
    output logic       DONE
);

    localparam logic [5:0] DRAIN_LAST = (HK_RD_LAT > 0) ? 6'(HK_RD_LAT - 1) : '0;

    state_t     state, state_nxt;
    logic [5:0] cnt, cnt_nxt;
    logic       done_nxt, flush;
    hk_tag_t    issue, tag;

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        done_nxt  = 1'b0;
        flush     = 1'b0;
        if (state == ST_INIT) begin
            if (MEM_RDY) state_nxt = ST_READY;
        end else if (!MEM_RDY) begin
            state_nxt = ST_INIT;
            cnt_nxt   = '0;
            flush     = 1'b1;
        end else if (ABORT) begin
            state_nxt = ST_READY;
            cnt_nxt   = '0;
            flush     = 1'b1;
        end else if (!STALL) begin
            case (state)
                ST_READY: if (START) begin
                    state_nxt = ST_LOAD_H;
                    cnt_nxt   = '0;
                end
                ST_LOAD_H: begin
                    cnt_nxt = cnt + 6'd1;
                    if (cnt == H_LAST) begin
                        cnt_nxt   = '0;
                        state_nxt = ST_ROUNDS;
                    end
                end
                ST_ROUNDS: begin
                    cnt_nxt = cnt + 6'd1;
                    if (cnt == K_LAST) begin
                        cnt_nxt   = '0;
                        state_nxt = ST_FINAL_H;
                    end
                end
                ST_FINAL_H: begin
                    cnt_nxt = cnt + 6'd1;
                    if (cnt == H_LAST) begin
                        cnt_nxt = '0;
                        // With no read latency there is nothing in flight to drain.
                        if (HK_RD_LAT == 0) begin
                            state_nxt = ST_READY;
                            done_nxt  = 1'b1;
                        end else begin
                            state_nxt = ST_DRAIN;
                        end
                    end
                end
                ST_DRAIN: begin
                    cnt_nxt = cnt + 6'd1;
                    if (cnt == DRAIN_LAST) begin
                        cnt_nxt   = '0;
                        state_nxt = ST_READY;
                        done_nxt  = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state       <= ST_INIT;
            cnt         <= '0;
            DONE        <= 1'b0;
            HK_SELECTOR <= HSEL;
            H_ADDR      <= '0;
            K_ADDR      <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            DONE  <= done_nxt;
            // Only the bank being walked is updated; the other address keeps its last value.
            case (state_nxt)
                ST_LOAD_H, ST_FINAL_H: begin
                    HK_SELECTOR <= HSEL;
                    H_ADDR      <= cnt_nxt[2:0];
                end
                ST_ROUNDS: begin
                    HK_SELECTOR <= KSEL;
                    K_ADDR      <= cnt_nxt;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        issue     = '0;
        issue.h_v = (state == ST_LOAD_H) || (state == ST_FINAL_H);
        issue.k_v = (state == ST_ROUNDS);
        issue.fin = (state == ST_FINAL_H);
        issue.idx = cnt;
    end

    hk_valid_pipe #(
        .HK_RD_LAT(HK_RD_LAT)
    ) u_valid_pipe (
        .clk  (CLK),
        .rst_n(RST_N),
        .en   (!STALL),
        .flush(flush),
        .din  (issue),
        .dout (tag)
    );

    assign H_VALID   = tag.h_v && !STALL;
    assign K_VALID   = tag.k_v && !STALL;
    assign FINAL     = tag.fin;
    assign IDX       = tag.idx;
    assign COPY_ROM  = (state == ST_INIT);
    assign INIT_DONE = (state == ST_READY);
    assign BUSY      = (state != ST_INIT) && (state != ST_READY);

endmodule

// File: tb/tb_sha256_hk_sequencer.sv
// Self-checking bench: HK memory stand-in, expected-word queue and a cycle-count timing model.
module tb_sha256_hk_sequencer;

    localparam int unsigned LAT   = 1;
    localparam int          WORDS = 80;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       start = 1'b0, stall = 1'b0, abort = 1'b0, mem_rdy = 1'b0;
    logic       copy_rom, hk_selector, h_valid, k_valid, fin, init_done, busy, done;
    logic [2:0] h_addr;
    logic [5:0] k_addr, idx;
    logic [31:0] hk;
    logic [31:0] h_tab [8];
    logic [31:0] k_tab [64];

    typedef struct { bit k; bit fin; int idx; logic [31:0] val; } word_t;
    typedef struct { int stall_at; int stall_len; int abort_at; int exp_done; int exp_words; } scen_t;

    word_t exp_q[$];
    word_t mon_w;
    scen_t table_v [7];
    int    checks = 0, errors = 0;
    int    tick = 0, start_tick = 0, done_cnt = 0, done_cyc = 0;
    bit    mon_on = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) tick++;

    sha256_hk_sequencer #(.HK_RD_LAT(LAT)) dut (
        .CLK(clk), .RST_N(rst_n), .START(start), .STALL(stall), .ABORT(abort), .MEM_RDY(mem_rdy),
        .COPY_ROM(copy_rom), .HK_SELECTOR(hk_selector), .H_ADDR(h_addr), .K_ADDR(k_addr),
        .H_VALID(h_valid), .K_VALID(k_valid), .FINAL(fin), .IDX(idx),
        .INIT_DONE(init_done), .BUSY(busy), .DONE(done)
    );

    // HK memory stand-in: one registered read stage, frozen together with the rest of the HK path on STALL.
    always @(posedge clk) if (!stall) hk <= hk_selector ? k_tab[k_addr] : h_tab[h_addr];

    always @(negedge clk) begin
        if (mon_on) begin
            if (h_valid || k_valid) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL extra_word: got h=%b k=%b idx=%0d hk=%h, expected no word", h_valid, k_valid, idx, hk);
                end else begin
                    mon_w = exp_q.pop_front();
                    if (h_valid !== 1'(!mon_w.k) || k_valid !== 1'(mon_w.k) || fin !== 1'(mon_w.fin) ||
                        idx !== 6'(mon_w.idx) || hk !== mon_w.val) begin
                        errors++;
                        $display("FAIL word: got h=%b k=%b fin=%b idx=%0d hk=%h, expected h=%b k=%b fin=%b idx=%0d hk=%h",
                                 h_valid, k_valid, fin, idx, hk, !mon_w.k, mon_w.k, mon_w.fin, mon_w.idx, mon_w.val);
                    end
                end
            end
            if (done) begin
                done_cnt++;
                done_cyc = tick - start_tick + 1;
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_block();
        word_t w;
        for (int i = 0; i < 8; i++) begin w.k = 0; w.fin = 0; w.idx = i; w.val = h_tab[i]; exp_q.push_back(w); end
        for (int i = 0; i < 64; i++) begin w.k = 1; w.fin = 0; w.idx = i; w.val = k_tab[i]; exp_q.push_back(w); end
        for (int i = 0; i < 8; i++) begin w.k = 0; w.fin = 1; w.idx = i; w.val = h_tab[i]; exp_q.push_back(w); end
    endtask

    // Word j leaves once j+LAT unstalled cycles precede it; DONE follows 80+LAT unstalled cycles.
    function automatic void model(input int sa, input int sl, input int ab, output int d, output int w);
        int b = 0;
        d = 0;
        w = 0;
        for (int c = 1; c <= 200; c++) begin
            bit st = (sl > 0 && c >= sa && c < sa + sl);
            if (ab != 0 && c > ab) break;
            if (b == WORDS + int'(LAT)) begin d = c; break; end
            if (!st && b >= int'(LAT) && b < WORDS + int'(LAT)) w++;
            if (!st) b++;
        end
    endfunction

    task automatic reset_and_init();
        rst_n = 1'b0; mem_rdy = 1'b0; start = 1'b0; stall = 1'b0; abort = 1'b0;
        #1;
        chk("reset_values", {copy_rom, init_done, busy, done, h_valid, k_valid, fin, hk_selector, h_addr, k_addr, idx},
            {1'b1, 22'd0});
        repeat (2) step();
        rst_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            step();
            chk("copy_running", {copy_rom, init_done, h_valid, k_valid}, 4'b1000);
        end
        mem_rdy = 1'b1;
        #1;
        chk("copy_last", {copy_rom, init_done}, 2'b10);
        step();
        chk("copy_done", {copy_rom, init_done, busy}, 3'b010);
    endtask

    task automatic run_scen(input string tag, input scen_t s);
        int c_end = 95 + s.stall_len;
        push_block();
        done_cnt = 0;
        done_cyc = 0;
        start = 1'b1;
        step();
        start = 1'b0;
        start_tick = tick;
        mon_on = 1'b1;
        for (int c = 1; c <= c_end; c++) begin
            stall = (s.stall_len > 0 && c >= s.stall_at && c < s.stall_at + s.stall_len);
            abort = (c == s.abort_at);
            if (s.abort_at != 0 && c == s.abort_at + 1)
                chk({tag, " abort_next"}, {busy, init_done, done, h_valid, k_valid}, 5'b01000);
            if (stall && c == s.stall_at) begin
                #1;
                chk({tag, " stall_mask"}, {h_valid, k_valid}, 2'b00);
            end
            step();
        end
        stall = 1'b0;
        abort = 1'b0;
        chk({tag, " done_count"}, done_cnt, (s.exp_done != 0) ? 1 : 0);
        chk({tag, " done_cycle"}, done_cyc, s.exp_done);
        chk({tag, " words"}, WORDS - exp_q.size(), s.exp_words);
        chk({tag, " idle"}, {busy, init_done}, 2'b01);
        exp_q.delete();
        mon_on = 1'b0;
    endtask

    initial begin
        scen_t s;
        int    d, w;
        h_tab = '{32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a, 32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};
        k_tab = '{32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
                  32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
                  32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
                  32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
                  32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
                  32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
                  32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
                  32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};
        // {stall_at, stall_len, abort_at, exp_done_cycle, exp_words}
        table_v = '{'{0, 0, 0, 82, 80},
                    '{40, 5, 0, 87, 80},
                    '{0, 0, 50, 0, 49},
                    '{2, 1, 0, 83, 80},
                    '{81, 3, 0, 85, 80},
                    '{0, 0, 1, 0, 0},
                    '{30, 4, 30, 0, 28}};
        #1;
        reset_and_init();

        for (int i = 0; i < 7; i++) run_scen($sformatf("row%0d", i), table_v[i]);

        for (int i = 0; i < 6; i++) begin
            s.stall_at  = int'($urandom_range(85, 1));
            s.stall_len = int'($urandom_range(6, 0));
            s.abort_at  = ($urandom_range(2, 0) == 0) ? int'($urandom_range(80, 1)) : 0;
            model(s.stall_at, s.stall_len, s.abort_at, d, w);
            s.exp_done  = d;
            s.exp_words = w;
            run_scen($sformatf("rand%0d", i), s);
        end

        // START held high across a whole block: exactly one new block begins right after DONE.
        push_block();
        push_block();
        done_cnt = 0;
        done_cyc = 0;
        start = 1'b1;
        step();
        start_tick = tick;
        mon_on = 1'b1;
        for (int c = 1; c <= 170; c++) begin
            if (c == 84) start = 1'b0;
            if (c == 40) chk("held_busy", {busy, init_done}, 2'b10);
            if (c == 82) chk("held_done", {done, busy, init_done}, 3'b101);
            if (c == 83) chk("held_restart", {busy, hk_selector, h_addr}, {1'b1, 1'b0, 3'd0});
            step();
        end
        chk("held_done_count", done_cnt, 2);
        chk("held_done_cycle", done_cyc, 164);
        chk("held_words_left", exp_q.size(), 0);
        exp_q.delete();
        mon_on = 1'b0;

        // MEM_RDY drop mid-block returns to INIT with no DONE.
        push_block();
        done_cnt = 0;
        start = 1'b1;
        step();
        start = 1'b0;
        start_tick = tick;
        mon_on = 1'b1;
        for (int c = 1; c <= 30; c++) step();
        mem_rdy = 1'b0;
        step();
        chk("memfail_init", {copy_rom, busy, init_done, h_valid, k_valid}, 5'b10000);
        mem_rdy = 1'b1;
        step();
        chk("memfail_ready", {copy_rom, init_done}, 2'b01);
        repeat (5) step();
        chk("memfail_words", WORDS - exp_q.size(), 30);
        chk("memfail_no_done", done_cnt, 0);
        exp_q.delete();
        mon_on = 1'b0;

        // Asynchronous reset while K[10] is on the bus.
        push_block();
        start = 1'b1;
        step();
        start = 1'b0;
        start_tick = tick;
        mon_on = 1'b1;
        for (int c = 1; c <= 19; c++) step();
        #2;
        chk("k10_on_bus", {k_valid, idx}, {1'b1, 6'd10});
        rst_n = 1'b0;
        #1;
        chk("async_reset", {copy_rom, init_done, busy, done, h_valid, k_valid, fin, hk_selector, h_addr, k_addr, idx},
            {1'b1, 22'd0});
        mon_on = 1'b0;
        exp_q.delete();
        reset_and_init();
        run_scen("post_reset", table_v[0]);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
